// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Widest operand the width-parametrised helpers can describe.
  localparam int MAX_WIDTH = 64;

  // All-ones quotient returned for a zero divisor, right-aligned in w bits.
  function automatic logic [MAX_WIDTH-1:0] div_by_zero_quot(input int w);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
  endfunction

  // Step counter width: enough for 0..w-1 with headroom, never below 5 bits.
  function automatic int cnt_width(input int w);
    return ($clog2(w) + 1 < 5) ? 5 : $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic             unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit is always
  // zero on entry; only the low WIDTH bits take part in the shift.
  assign unused_rem_msb = rem_in[WIDTH];

  // Trial subtraction one bit wider than the remainder exposes the borrow.
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], next_bit};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    borrow  = trial[WIDTH+1];
    q_bit   = ~borrow;
    rem_out = borrow ? shifted : trial[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider, one quotient bit per cycle, with valid/ready
// operand and result ports.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE; out_valid is high only in DONE and
// the result is held stable until the consumer raises out_ready.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_t       state_dbg
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIV_BY_ZERO_QUOT = WIDTH'(div_by_zero_quot(WIDTH));

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvsr_reg;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (r_reg),
    .next_bit (q_reg[WIDTH-1]),
    .divisor  (dvsr_reg),
    .rem_out  (step_rem),
    .q_bit    (step_bit)
  );

  // Dividend bits leave from the top of Q while quotient bits enter at the bottom.
  assign step_q    = {q_reg[WIDTH-2:0], step_bit};
  assign state_dbg = state;

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      dvsr_reg    <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor skips the iteration; the result is known now
              // and is published one cycle later from DONE.
              state       <= DONE;
              quotient    <= DIV_BY_ZERO_QUOT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              cnt         <= '0;
              r_reg       <= '0;
              q_reg       <= dividend;
              dvsr_reg    <= divisor;
              div_by_zero <= 1'b0;
            end
          end
        end

        CALC: begin
          r_reg <= step_rem;
          q_reg <= step_q;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= step_q;
            remainder <= step_rem[WIDTH-1:0];
          end
        end

        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases plus randomized operands
// checked against a plain-arithmetic reference model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W      = 16;
  localparam int N_RAND = 2000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  div_state_t   state_dbg;

  int n_cmp;
  int n_err;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_z[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference model: integer division, with the zero-divisor convention.
  task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) begin
      exp_q.push_back({W{1'b1}});
      exp_r.push_back(a);
      exp_z.push_back(1'b1);
    end else begin
      exp_q.push_back(a / b);
      exp_r.push_back(a % b);
      exp_z.push_back(1'b0);
    end
  endtask

  // driver: wait for in_ready, present operands for exactly the accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    push_expect(a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // edges from the accept edge until out_valid is seen
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic compare_result(input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_noexp"}, 32'd1, 32'd0);
      return;
    end
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    ez = exp_z.pop_front();
    check_eq({tag, "_quot"}, 32'(quotient), 32'(eq));
    check_eq({tag, "_rem"}, 32'(remainder), 32'(er));
    check_eq({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // one full operation: send, check latency and result, hand it off
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    send(a, b);
    wait_out(lat);
    check_eq({tag, "_lat"}, 32'(lat), (b == '0) ? 32'd1 : 32'(W));
    compare_result(tag);
    consume();
    check_eq({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    int           stall;
    logic [31:0]  recon;

    n_cmp     = 0;
    n_err     = 0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;

    apply_reset();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_quot", 32'(quotient), 32'd0);
    check_eq("rst_rem", 32'(remainder), 32'd0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'd0);

    // basic and boundary operands
    run_op("d100_7", 16'd100, 16'd7);
    run_op("dffff_1", 16'hFFFF, 16'd1);
    run_op("dffff_ffff", 16'hFFFF, 16'hFFFF);
    run_op("d5_9", 16'd5, 16'd9);
    run_op("d1234_0", 16'd1234, 16'd0);
    run_op("d10_3", 16'd10, 16'd3);

    // consumer stall with ignored operand pulses
    send(16'd200, 16'd9);
    wait_out(lat);
    check_eq("stall_lat", 32'(lat), 32'(W));
    compare_result("stall");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom_range(0, 65535));
      divisor  = 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
      check_eq("stall_ov", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_quot", 32'(quotient), 32'd22);
      check_eq("stall_rem", 32'(remainder), 32'd2);
    end
    in_valid = 1'b0;
    consume();
    check_eq("stall_ov_clr", 32'(out_valid), 32'd0);
    check_eq("stall_rdy_back", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("stall_no_ghost", 32'(out_valid), 32'd0);
    end

    // reset during CALC aborts the operation
    send(16'd500, 16'd3);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_r.delete();
    exp_z.delete();
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_quot", 32'(quotient), 32'd0);
    check_eq("midrst_rem", 32'(remainder), 32'd0);
    check_eq("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) check_eq("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_op("d500_3", 16'd500, 16'd3);

    // randomized operands with random consumer stalls
    for (int n = 0; n < N_RAND; n++) begin
      a = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = 16'($urandom_range(1, 15));
        3:       b = 16'($urandom_range(1, 255));
        4:       b = a;
        default: b = 16'($urandom_range(1, 65535));
      endcase
      send(a, b);
      wait_out(lat);
      check_eq("rand_lat", 32'(lat), (b == '0) ? 32'd1 : 32'(W));
      if (b != '0) begin
        recon = 32'(quotient) * 32'(b) + 32'(remainder);
        check_eq("rand_invariant", recon, 32'(a));
        check_eq("rand_rem_lt_div", 32'(remainder < b), 32'd1);
      end
      compare_result("rand");
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check_eq("rand_hold_ov", 32'(out_valid), 32'd1);
      end
      consume();
      check_eq("rand_ov_clr", 32'(out_valid), 32'd0);
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
